// File: rtl/dmem_pkg.sv
// dmem_pkg: shared state/op encodings and big-endian lane order for data_mem_responder
package dmem_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, ACCESS = 2'd2, DONE = 2'd3} state_e;
  typedef enum logic {OP_RD = 1'b0, OP_WR = 1'b1} op_e;
  localparam int LANES = 4;
  // byte offset i of a word lives in data lane / ByteEn bit LANE_BIT[i]
  localparam int LANE_BIT [LANES] = '{3, 2, 1, 0};
endpackage

// File: rtl/dmem_byte_array.sv
// dmem_byte_array: byte-wide storage with a 4-lane big-endian word port and lane enables
module dmem_byte_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_BYTES = 128,
  localparam int IW = $clog2(DEPTH_BYTES)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    lane_en,
  input  logic [IW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  logic [7:0] mem [DEPTH_BYTES] = '{default: 8'h00};
  always_ff @(posedge clk)
    if (we)
      for (int i = 0; i < LANES; i++)
        if (lane_en[LANE_BIT[i]]) mem[addr + IW'(i)] <= wdata[8*LANE_BIT[i] +: 8];
  always_comb begin
    rdata = '0;
    for (int i = 0; i < LANES; i++)
      rdata[8*LANE_BIT[i] +: 8] = lane_en[LANE_BIT[i]] ? mem[addr + IW'(i)] : 8'h00;
  end
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: multi-cycle big-endian data memory with programmable wait states.
// Define DMEM_BYTE_LANE_EN to add the ByteEn lane-enable input.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_BYTES = 128,
  parameter int WAIT_CYCLES = 1,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mRD,
  input  logic              mWR,
  input  logic [ADDR_W-1:0] DAddr,
  input  logic [31:0]       DataIn,
`ifdef DMEM_BYTE_LANE_EN
  input  logic [3:0]        ByteEn,
`endif
  output logic [31:0]       DataOut,
  output logic              mReady,
  output logic              mBusy,
  output logic              mErr
);
  localparam int IW = $clog2(DEPTH_BYTES);
  state_e        state_q;
  op_e           op_q;
  logic          err_q, req_err;
  logic [3:0]    cnt_q, be_q, be_in;
  logic [IW-1:0] idx_q;
  logic [31:0]   din_q, rdata;
`ifdef DMEM_BYTE_LANE_EN
  assign be_in = ByteEn;
`else
  assign be_in = 4'hF;
`endif
  assign req_err = (DAddr[1:0] != 2'b00) || (DAddr > ADDR_W'(DEPTH_BYTES - 4)) || (mRD && mWR);
  assign mBusy   = state_q != IDLE;
  // a rejected request never indexes the array with its out-of-range address
  dmem_byte_array #(.DEPTH_BYTES(DEPTH_BYTES)) u_arr (
    .clk    (clk),
    .we     (state_q == ACCESS && op_q == OP_WR && !err_q),
    .lane_en(be_q),
    .addr   (err_q ? '0 : idx_q),
    .wdata  (din_q),
    .rdata  (rdata)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      op_q    <= OP_RD;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      be_q    <= '0;
      idx_q   <= '0;
      din_q   <= '0;
      DataOut <= '0;
      mReady  <= 1'b0;
      mErr    <= 1'b0;
    end else
      case (state_q)
        IDLE: if (mRD || mWR) begin
          idx_q   <= DAddr[IW-1:0];
          din_q   <= DataIn;
          be_q    <= be_in;
          op_q    <= mWR ? OP_WR : OP_RD;
          err_q   <= req_err;
          cnt_q   <= 4'(WAIT_CYCLES - 1);
          state_q <= WAIT_CYCLES > 0 ? WAIT : ACCESS;
        end
        WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd0) state_q <= ACCESS;
        end
        ACCESS: begin
          if (err_q || op_q == OP_RD) DataOut <= err_q ? '0 : rdata;
          mReady  <= 1'b1;
          mErr    <= err_q;
          state_q <= DONE;
        end
        DONE: if (!mRD && !mWR) begin
          mReady  <= 1'b0;
          mErr    <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: randomized + directed bench with a transaction-level memory model
module tb_data_mem_responder;
  localparam int DEPTH = 128;
  logic clk = 1'b0, rst = 1'b0;
  always #5 clk = ~clk;

  logic rd = 0, wr = 0, busy, rdy, err;
  logic [31:0] addr = 0, din = 0, dout;
  logic [3:0] be = 4'hF;
  logic rd3 = 0, wr3 = 0, busy3, rdy3, err3;
  logic [31:0] addr3 = 0, din3 = 0, dout3;
  logic [3:0] be3 = 4'hF;

  data_mem_responder #(.DEPTH_BYTES(DEPTH), .WAIT_CYCLES(1), .ADDR_W(32)) u_dut (
    .clk(clk), .rst(rst), .mRD(rd), .mWR(wr), .DAddr(addr), .DataIn(din),
`ifdef DMEM_BYTE_LANE_EN
    .ByteEn(be),
`endif
    .DataOut(dout), .mReady(rdy), .mBusy(busy), .mErr(err));

  data_mem_responder #(.DEPTH_BYTES(DEPTH), .WAIT_CYCLES(3), .ADDR_W(32)) u_dut3 (
    .clk(clk), .rst(rst), .mRD(rd3), .mWR(wr3), .DAddr(addr3), .DataIn(din3),
`ifdef DMEM_BYTE_LANE_EN
    .ByteEn(be3),
`endif
    .DataOut(dout3), .mReady(rdy3), .mBusy(busy3), .mErr(err3));

  int checks = 0, failures = 0;
  logic [7:0] mm [DEPTH];
  logic exp_busy = 0, exp_rdy = 0, exp_err = 0;
  logic [31:0] exp_dout = 0;
  bit chk_en = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, expv, $time);
    end
  endtask

  always @(negedge clk)
    if (chk_en) begin
      chk("busy", busy, exp_busy);
      chk("ready", rdy, exp_rdy);
      chk("err", err, exp_err);
      chk("dataout", dout, exp_dout);
    end

  function automatic logic model_err(input logic r, input logic w, input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a > 32'(DEPTH - 4)) || (r && w);
  endfunction

  // one request on the WAIT_CYCLES=1 instance; expectations follow capture E0 -> ready after E0+2
  task automatic req(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] b, input bit scramble, output logic [31:0] q, output logic e_o);
    logic e;
    logic [31:0] word;
    @(negedge clk); rd = r; wr = w; addr = a; din = d; be = b;
    e = model_err(r, w, a);
    @(posedge clk); #1 exp_busy = 1;
    @(negedge clk);
    if (scramble) begin
      rd = 1'($urandom); wr = 1'($urandom); addr = $urandom; din = $urandom; be = 4'($urandom);
    end
    @(posedge clk);
    @(posedge clk); #1;
    if (e) exp_dout = 0;
    else if (w) begin
      for (int i = 0; i < 4; i++) if (b[3-i]) mm[a + i] = d[8*(3-i) +: 8];
    end else begin
      word = 0;
      for (int i = 0; i < 4; i++) if (b[3-i]) word[8*(3-i) +: 8] = mm[a + i];
      exp_dout = word;
    end
    exp_rdy = 1; exp_err = e;
    q = dout; e_o = err;
    repeat ($urandom_range(0, 2)) begin
      @(negedge clk); rd = 1; wr = 0;
      @(posedge clk);
    end
    @(negedge clk); rd = 0; wr = 0;
    @(posedge clk); #1 exp_busy = 0; exp_rdy = 0; exp_err = 0;
  endtask

  task automatic req3(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                      output logic [31:0] q);
    int n = 0;
    @(negedge clk); rd3 = r; wr3 = w; addr3 = a; din3 = d;
    @(posedge clk); #1;
    while (!rdy3 && n < 20) begin @(posedge clk); #1; n++; end
    chk("req3_ready_seen", rdy3, 1'b1);
    q = dout3;
    @(negedge clk); rd3 = 0; wr3 = 0;
    @(posedge clk);
  endtask

  initial begin
    logic [31:0] q, a;
    logic e;
    logic r, w;
    int sel;
    for (int i = 0; i < DEPTH; i++) mm[i] = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0); chk("rst_ready", rdy, 0);
    chk("rst_err", err, 0); chk("rst_dataout", dout, 0);
    chk("rst_busy3", busy3, 0);
    @(negedge clk); rst = 1; chk_en = 1;

    // write then read back, big-endian byte placement
    req(0, 1, 8, 32'h12345678, 4'hF, 0, q, e);
    chk("t1_wr_err", e, 0);
    req(1, 0, 8, 32'h0, 4'hF, 1, q, e);
    chk("t1_rd_data", q, 32'h12345678);
    chk("t1_mem8", u_dut.u_arr.mem[8], 8'h12);
    chk("t1_mem11", u_dut.u_arr.mem[11], 8'h78);

    // misalignment and range boundaries
    req(1, 0, 6, 32'h0, 4'hF, 0, q, e);
    chk("t2_misalign_err", e, 1); chk("t2_misalign_data", q, 0);
    req(0, 1, 124, 32'hA1B2C3D4, 4'hF, 0, q, e);
    chk("t2_top_err", e, 0);
    req(0, 1, 128, 32'h55555555, 4'hF, 0, q, e);
    chk("t2_oob_err", e, 1);
    req(0, 1, 32'h0000_0108, 32'h66666666, 4'hF, 0, q, e);
    chk("t2_alias_err", e, 1);
    req(1, 0, 32'hFFFF_FFFC, 32'h0, 4'hF, 0, q, e);
    chk("t2_high_err", e, 1);
    req(1, 0, 124, 32'h0, 4'hF, 0, q, e);
    chk("t2_top_data", q, 32'hA1B2C3D4);
    req(1, 0, 8, 32'h0, 4'hF, 0, q, e);
    chk("t2_alias_untouched", q, 32'h12345678);

    // both strobes at capture
    req(0, 1, 0, 32'hCAFEF00D, 4'hF, 0, q, e);
    req(1, 1, 0, 32'h0, 4'hF, 0, q, e);
    chk("t3_both_err", e, 1); chk("t3_both_data", q, 0);
    req(1, 0, 0, 32'h0, 4'hF, 0, q, e);
    chk("t3_mem0_kept", q, 32'hCAFEF00D);

    // reset during WAIT aborts a write
    req(0, 1, 16, 32'h0BADF00D, 4'hF, 0, q, e);
    @(negedge clk); rd = 0; wr = 1; addr = 16; din = 32'hDEADBEEF;
    @(posedge clk); #1 exp_busy = 1;
    #1 rst = 0;
    #1 exp_busy = 0; exp_rdy = 0; exp_err = 0; exp_dout = 0;
    chk("t5_busy", busy, 0); chk("t5_ready", rdy, 0);
    chk("t5_err", err, 0); chk("t5_dataout", dout, 0);
    wr = 0;
    @(negedge clk); #2 rst = 1;
    req(1, 0, 16, 32'h0, 4'hF, 0, q, e);
    chk("t5_mem16_kept", q, 32'h0BADF00D);

`ifdef DMEM_BYTE_LANE_EN
    req(0, 1, 20, 32'h00000000, 4'hF, 0, q, e);
    req(0, 1, 20, 32'hFFFFFFFF, 4'b0101, 0, q, e);
    chk("t6_lane_wr_err", e, 0);
    req(0, 1, 20, 32'h12121212, 4'b0000, 0, q, e);
    chk("t6_noop_err", e, 0);
    req(1, 0, 20, 32'h0, 4'hF, 0, q, e);
    chk("t6_lane_data", q, 32'h00FF00FF);
    req(1, 0, 20, 32'h0, 4'b0011, 0, q, e);
    chk("t6_lane_rd_mask", q, 32'h000000FF);
`endif

    // WAIT_CYCLES=3: inputs changed during WAIT are ignored, ready after E0+4
    @(negedge clk); wr3 = 1; addr3 = 4; din3 = 32'hAABBCCDD;
    @(posedge clk);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) begin wr3 = 0; addr3 = 8; din3 = 32'h11111111; end
      @(posedge clk); #1;
      chk($sformatf("t4_ready_e%0d", k), rdy3, k == 4);
    end
    chk("t4_err", err3, 0);
    @(posedge clk); #1;
    chk("t4_ready_drop", rdy3, 0);
    req3(1, 0, 4, 32'h0, q);
    chk("t4_data", q, 32'hAABBCCDD);
    req3(1, 0, 8, 32'h0, q);
    chk("t4_ignored_addr", q, 32'h0);

    // randomized traffic against the model
    for (int n = 0; n < 200; n++) begin
      sel = int'($urandom_range(0, 7));
      a = sel < 5 ? 32'($urandom_range(0, 31) * 4) :
          sel == 5 ? 32'($urandom_range(0, 31) * 4 + $urandom_range(1, 3)) :
          sel == 6 ? 32'(124 + 4 * $urandom_range(1, 3)) : $urandom;
      sel = int'($urandom_range(0, 7));
      r = sel < 3 || sel == 7;
      w = sel >= 3;
`ifdef DMEM_BYTE_LANE_EN
      req(r, w, a, $urandom, 4'($urandom), 1'($urandom), q, e);
`else
      req(r, w, a, $urandom, 4'hF, 1'($urandom), q, e);
`endif
    end

    for (int i = 0; i < DEPTH; i++) chk($sformatf("mem_final_%0d", i), u_dut.u_arr.mem[i], mm[i]);
    chk_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
